// File: rtl/gates_pkg.sv
// Shared types, err_vec bit positions and the golden truth table for the gates BIST.
package gates_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int NOT_B  = 2;
    localparam int XOR_B  = 3;
    localparam int NAND_B = 4;
    localparam int NOR_B  = 5;
    localparam int XNOR_B = 6;

    // "not" is taken from input a only.
    function automatic logic [6:0] gate_ref(input logic a, input logic b);
        logic [6:0] r;
        r         = '0;
        r[AND_B]  = a & b;
        r[OR_B]   = a | b;
        r[NOT_B]  = ~a;
        r[XOR_B]  = a ^ b;
        r[NAND_B] = ~(a & b);
        r[NOR_B]  = ~(a | b);
        r[XNOR_B] = ~(a ^ b);
        return r;
    endfunction

endpackage

// File: rtl/gates_bist_cmp.sv
// Combinational compare of observed gate outputs against the golden table.
module gates_bist_cmp
    import gates_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [6:0] obs,
    output logic [6:0] mismatch,
    output logic [2:0] mis_cnt
);

    always_comb begin
        mismatch = obs ^ gate_ref(a, b);
        mis_cnt  = '0;
        for (int i = 0; i < 7; i++) begin
            mis_cnt = mis_cnt + {2'b00, mismatch[i]};
        end
    end

endmodule

// File: rtl/gates_bist.sv
// BIST controller: sweeps a/b through 00,01,10,11, samples the seven gate outputs
// after a settle time and accumulates sticky error flags and a saturating count.
//
// state  | meaning
// IDLE   | a/b parked at 0, waiting for start
// DRIVE  | load a/b from the current vector
// SETTLE | hold a/b for SETTLE_CYCLES cycles
// CHECK  | compare outputs, accumulate errors, pick next vector/loop
// DONE   | one-cycle done pulse, pass already valid
module gates_bist
    import gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       and_i,
    input  logic       or_i,
    input  logic       not_i,
    input  logic       xor_i,
    input  logic       nand_i,
    input  logic       nor_i,
    input  logic       xnor_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_vec,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_LOOP   = 4'(LOOPS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] vec;
    logic [3:0] loop_cnt;
    logic [3:0] settle_cnt;
    logic [6:0] obs;
    logic [6:0] mismatch;
    logic [2:0] mis_cnt;
    logic [8:0] cnt_sum;
    logic [7:0] cnt_sat;
    logic       last_vec;

    assign obs = {xnor_i, nor_i, nand_i, xor_i, not_i, or_i, and_i};

    gates_bist_cmp u_cmp (
        .a        (a_o),
        .b        (b_o),
        .obs      (obs),
        .mismatch (mismatch),
        .mis_cnt  (mis_cnt)
    );

    assign cnt_sum  = {1'b0, err_cnt} + {6'd0, mis_cnt};
    assign cnt_sat  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    assign last_vec = (vec == 2'd3) && (loop_cnt >= LAST_LOOP);

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_nxt = CHECK;
            CHECK:   state_nxt = last_vec ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            pass       <= 1'b0;
            err_vec    <= '0;
            err_cnt    <= '0;
            vec        <= '0;
            loop_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_vec    <= '0;
                        err_cnt    <= '0;
                        pass       <= 1'b0;
                        vec        <= '0;
                        loop_cnt   <= '0;
                        settle_cnt <= '0;
                    end
                end
                DRIVE: begin
                    a_o        <= vec[1];
                    b_o        <= vec[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    err_vec <= err_vec | mismatch;
                    err_cnt <= cnt_sat;
                    if (vec != 2'd3) begin
                        vec <= vec + 2'd1;
                    end else if (loop_cnt < LAST_LOOP) begin
                        vec      <= '0;
                        loop_cnt <= loop_cnt + 4'd1;
                    end else begin
                        // Include this final sample so pass is valid alongside done.
                        pass <= ((err_vec | mismatch) == 7'd0);
                    end
                end
                DONE: begin
                    a_o <= 1'b0;
                    b_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_bist.sv
// Directed bench for gates_bist: three instances (LOOPS 1/3/15) driven by a
// behavioural gates block with selectable faults.
module tb_gates_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [6:0] ev_v [3];
    logic [7:0] ec_v [3];
    logic [6:0] g_v  [3];
    int         fault [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // mode 0: good, 1: xor stuck at 0, 2: not follows a, 3: all outputs inverted
    function automatic logic [6:0] gates_model(input logic a, input logic b, input int mode);
        logic [6:0] g;
        g = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, ~a, a | b, a & b};
        case (mode)
            1:       g[3] = 1'b0;
            2:       g[2] = a;
            3:       g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    assign g_v[0] = gates_model(a_v[0], b_v[0], fault[0]);
    assign g_v[1] = gates_model(a_v[1], b_v[1], fault[1]);
    assign g_v[2] = gates_model(a_v[2], b_v[2], fault[2]);

    gates_bist #(.SETTLE_CYCLES(2), .LOOPS(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_o(a_v[0]), .b_o(b_v[0]),
        .and_i(g_v[0][0]), .or_i(g_v[0][1]), .not_i(g_v[0][2]), .xor_i(g_v[0][3]),
        .nand_i(g_v[0][4]), .nor_i(g_v[0][5]), .xnor_i(g_v[0][6]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_vec(ev_v[0]), .err_cnt(ec_v[0])
    );

    gates_bist #(.SETTLE_CYCLES(2), .LOOPS(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_o(a_v[1]), .b_o(b_v[1]),
        .and_i(g_v[1][0]), .or_i(g_v[1][1]), .not_i(g_v[1][2]), .xor_i(g_v[1][3]),
        .nand_i(g_v[1][4]), .nor_i(g_v[1][5]), .xnor_i(g_v[1][6]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_vec(ev_v[1]), .err_cnt(ec_v[1])
    );

    gates_bist #(.SETTLE_CYCLES(2), .LOOPS(15)) u_l15 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_o(a_v[2]), .b_o(b_v[2]),
        .and_i(g_v[2][0]), .or_i(g_v[2][1]), .not_i(g_v[2][2]), .xor_i(g_v[2][3]),
        .nand_i(g_v[2][4]), .nor_i(g_v[2][5]), .xnor_i(g_v[2][6]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_vec(ev_v[2]), .err_cnt(ec_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Pulse start on instance d and sample n cycles after the start edge.
    // k=1 is the first sample after the start edge; extra_k re-pulses start mid-run.
    task automatic run_dut(input int d, input int n, input int extra_k,
                           output int busy_n, output int done_n, output int done_at,
                           output logic [7:0] ab_cap, output logic [7:0] ec_k1);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        ab_cap  = '0;
        ec_k1   = '0;
        @(negedge clk);
        start_v[d] = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 || k == extra_k + 1) start_v[d] = 1'b0;
            if (k == extra_k) start_v[d] = 1'b1;
            if (k == 1) ec_k1 = ec_v[d];
            if (busy_v[d]) busy_n++;
            if (done_v[d]) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            case (k)
                3:  ab_cap[7:6] = {a_v[d], b_v[d]};
                7:  ab_cap[5:4] = {a_v[d], b_v[d]};
                11: ab_cap[3:2] = {a_v[d], b_v[d]};
                15: ab_cap[1:0] = {a_v[d], b_v[d]};
                default: ;
            endcase
        end
    endtask

    initial begin
        int         busy_n, done_n, done_at, late_done;
        logic [7:0] ab_cap, ec_k1;

        fault[0] = 0;
        fault[1] = 0;
        fault[2] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ab",   {30'd0, a_v[0], b_v[0]}, 32'd0);
        check("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check("rst_done", {31'd0, done_v[0]}, 32'd0);
        check("rst_pass", {31'd0, pass_v[0]}, 32'd0);
        check("rst_ev",   {25'd0, ev_v[0]}, 32'd0);
        check("rst_ec",   {24'd0, ec_v[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Golden run, LOOPS=1: busy 16 cycles, done at sample 17.
        run_dut(0, 22, 0, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("gold_busy",   busy_n, 16);
        check("gold_done_n", done_n, 1);
        check("gold_done_t", done_at, 17);
        check("gold_seq",    {24'd0, ab_cap}, 32'h1B);
        check("gold_pass",   {31'd0, pass_v[0]}, 32'd1);
        check("gold_ev",     {25'd0, ev_v[0]}, 32'd0);
        check("gold_ec",     {24'd0, ec_v[0]}, 32'd0);
        check("gold_ab_idle", {30'd0, a_v[0], b_v[0]}, 32'd0);

        // Second start 5 cycles in must be ignored.
        run_dut(0, 22, 5, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("rebusy_busy",   busy_n, 16);
        check("rebusy_done_n", done_n, 1);
        check("rebusy_done_t", done_at, 17);
        check("rebusy_pass",   {31'd0, pass_v[0]}, 32'd1);
        check("rebusy_ec",     {24'd0, ec_v[0]}, 32'd0);

        // xor stuck at 0: misses at 01 and 10.
        fault[0] = 1;
        run_dut(0, 22, 0, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("xor_ev",   {25'd0, ev_v[0]}, 32'h08);
        check("xor_ec",   {24'd0, ec_v[0]}, 32'd2);
        check("xor_pass", {31'd0, pass_v[0]}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("xor_hold_ev", {25'd0, ev_v[0]}, 32'h08);

        // Next accepted start clears the results.
        fault[0] = 0;
        run_dut(0, 22, 0, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("clr_ec_k1", {24'd0, ec_k1}, 32'd0);
        check("clr_pass",  {31'd0, pass_v[0]}, 32'd1);

        // not follows a, LOOPS=3: 12 misses, done at sample 49.
        fault[1] = 2;
        run_dut(1, 54, 0, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("not_ev",     {25'd0, ev_v[1]}, 32'h04);
        check("not_ec",     {24'd0, ec_v[1]}, 32'd12);
        check("not_pass",   {31'd0, pass_v[1]}, 32'd0);
        check("not_done_t", done_at, 49);
        check("not_busy",   busy_n, 48);

        // All inverted, LOOPS=15: 420 raw misses saturate at 255.
        fault[2] = 3;
        run_dut(2, 246, 0, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("sat_ev",     {25'd0, ev_v[2]}, 32'h7F);
        check("sat_ec",     {24'd0, ec_v[2]}, 32'd255);
        check("sat_pass",   {31'd0, pass_v[2]}, 32'd0);
        check("sat_done_t", done_at, 241);

        // Reset during SETTLE of vector 10 (sample 10), with an error already latched.
        fault[0] = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_ab_pre", {30'd0, a_v[0], b_v[0]}, 32'd2);
        check("mid_ev_pre", {25'd0, ev_v[0]}, 32'h08);
        rst_n = 1'b0;
        #1;
        check("mid_ab",   {30'd0, a_v[0], b_v[0]}, 32'd0);
        check("mid_busy", {31'd0, busy_v[0]}, 32'd0);
        check("mid_ev",   {25'd0, ev_v[0]}, 32'd0);
        check("mid_ec",   {24'd0, ec_v[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) late_done++;
        end
        check("mid_no_done", late_done, 0);

        fault[0] = 0;
        run_dut(0, 22, 0, busy_n, done_n, done_at, ab_cap, ec_k1);
        check("post_done_t", done_at, 17);
        check("post_pass",   {31'd0, pass_v[0]}, 32'd1);
        check("post_ec",     {24'd0, ec_v[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
